window_broadcaster: RTL and testbench

- Stage directly downstream of the positioner.
- Each time the positioner finishes a round, it scans the padded-image window [x_min..x_max] × [y_min..y_max] in raster order and reads the needed pixels from the layer's image memory.
- Each pixel goes out on a single broadcast bus, tagged with its padded coordinates. Allocators capture the pixels under their filter footprint.
- A done pulse at the end of the scan lets the issue controller raise advance for the next round.

---
 rtl/window_broadcaster_pkg.sv | 22 ++
 rtl/window_broadcaster_scanner.sv | 82 ++++++++
 rtl/window_broadcaster.sv | 135 +++++++++++++
 tb/tb_window_broadcaster.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_broadcaster_pkg.sv
// Shared definitions for the window broadcaster: widths, state encoding, helpers.
package window_broadcaster_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned COORD_W    = 8;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [1:0]         state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SCAN  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_FIN   = 2'd3;

  // A window with either bound pair inverted contains no coordinates.
  function automatic logic window_empty(input coord_t xmn, input coord_t xmx,
                                        input coord_t ymn, input coord_t ymx);
    return (xmn > xmx) || (ymn > ymx);
  endfunction

endpackage

// File: rtl/window_broadcaster_scanner.sv
// Raster walker over the latched window: coordinates, last detection, image hit and address.
module window_scanner
  import window_broadcaster_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [7:0]         x_min,
  input  logic [7:0]         x_max,
  input  logic [7:0]         y_min,
  input  logic [7:0]         y_max,
  input  logic [1:0]         padding,
  input  logic [7:0]         image_dim,
  output logic [7:0]         cx,
  output logic [7:0]         cy,
  output logic               in_img,
  output logic               last,
  output logic [ADDR_W-1:0]  addr
);

  coord_t     xmn_l;
  coord_t     xmx_l;
  coord_t     ymx_l;
  logic [1:0] pad_l;
  coord_t     dim_l;

  logic [8:0]  cx9;
  logic [8:0]  cy9;
  logic [8:0]  pad9;
  logic [8:0]  lim9;
  logic [7:0]  rx;
  logic [7:0]  ry;
  logic [15:0] prod;
  logic [15:0] sum16;

  // Latch the window on load, then walk it in raster order one step per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      xmn_l <= '0;
      xmx_l <= '0;
      ymx_l <= '0;
      pad_l <= '0;
      dim_l <= '0;
      cx    <= '0;
      cy    <= '0;
    end else if (load) begin
      xmn_l <= x_min;
      xmx_l <= x_max;
      ymx_l <= y_max;
      pad_l <= padding;
      dim_l <= image_dim;
      cx    <= x_min;
      cy    <= y_min;
    end else if (step) begin
      if (cx == xmx_l) begin
        cx <= xmn_l;
        cy <= cy + 8'd1;
      end else begin
        cx <= cx + 8'd1;
      end
    end
  end

  // Image-hit test at 9 bits so dim+pad and the bounds never wrap; address is row-major unpadded.
  always_comb begin
    cx9    = {1'b0, cx};
    cy9    = {1'b0, cy};
    pad9   = {7'b0, pad_l};
    lim9   = {1'b0, dim_l} + pad9;
    in_img = (cx9 >= pad9) && (cx9 < lim9) && (cy9 >= pad9) && (cy9 < lim9);
    last   = (cx == xmx_l) && (cy == ymx_l);
    rx     = cx - {6'b0, pad_l};
    ry     = cy - {6'b0, pad_l};
    prod   = {8'b0, ry} * {8'b0, dim_l};
    sum16  = prod + {8'b0, rx};
    addr   = ADDR_W'(sum16);
  end

endmodule

// File: rtl/window_broadcaster.sv
// Window broadcaster: scans the padded window per round and broadcasts tagged pixels.
module window_broadcaster
  import window_broadcaster_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        image_dim,
  input  logic [1:0]        padding,
  input  logic [7:0]        x_min,
  input  logic [7:0]        x_max,
  input  logic [7:0]        y_min,
  input  logic [7:0]        y_max,
  input  logic              round,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_data,
  output logic [7:0]        bcast_x,
  output logic [7:0]        bcast_y,
  output logic [DATA_W-1:0] bcast_pixel,
  output logic              bcast_valid,
  output logic              bcast_busy,
  output logic              bcast_done,
  output logic              overrun
);

  state_t            state;
  state_t            state_n;
  logic              round_q;
  logic              start;
  logic              accept;
  logic              issue;
  logic [7:0]        cx;
  logic [7:0]        cy;
  logic              in_img;
  logic              last;
  logic [ADDR_W-1:0] scan_addr;
  logic [ADDR_W-1:0] addr_q;
  logic              in_img_q;

  assign start  = round && !round_q;
  // FIN is accepted as idle-equivalent so back-to-back rounds lose no cycle.
  assign accept = start && ((state == ST_IDLE) || (state == ST_FIN));
  assign issue  = (state == ST_SCAN);

  window_scanner #(.ADDR_W(ADDR_W)) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (issue),
    .x_min     (x_min),
    .x_max     (x_max),
    .y_min     (y_min),
    .y_max     (y_max),
    .padding   (padding),
    .image_dim (image_dim),
    .cx        (cx),
    .cy        (cy),
    .in_img    (in_img),
    .last      (last),
    .addr      (scan_addr)
  );

  // Round edge detection, state register and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_q <= 1'b0;
      state   <= ST_IDLE;
      overrun <= 1'b0;
    end else begin
      round_q <= round;
      state   <= state_n;
      if (start && ((state == ST_SCAN) || (state == ST_DRAIN))) begin
        overrun <= 1'b1;
      end
    end
  end

  // Next-state: start (from IDLE or FIN) -> SCAN or straight to FIN when empty.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n = window_empty(x_min, x_max, y_min, y_max) ? ST_FIN : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (last) begin
          state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: state_n = ST_FIN;
      ST_FIN: begin
        if (accept) begin
          state_n = window_empty(x_min, x_max, y_min, y_max) ? ST_FIN : ST_SCAN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // One-cycle output pipeline; the address register holds across padding coordinates.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      bcast_valid <= 1'b0;
      bcast_x     <= '0;
      bcast_y     <= '0;
      in_img_q    <= 1'b0;
    end else begin
      if (issue && in_img) begin
        addr_q <= scan_addr;
      end
      bcast_valid <= issue;
      bcast_x     <= issue ? cx : '0;
      bcast_y     <= issue ? cy : '0;
      in_img_q    <= issue && in_img;
    end
  end

  // Memory strobe/address for the coordinate issued this cycle; padding beats carry zero.
  always_comb begin
    mem_en      = issue && in_img;
    mem_addr    = mem_en ? scan_addr : addr_q;
    bcast_pixel = in_img_q ? mem_data : '0;
    bcast_busy  = (state != ST_IDLE);
    bcast_done  = (state == ST_FIN);
  end

endmodule

// File: tb/tb_window_broadcaster.sv
// Randomized and directed bench for window_broadcaster against a per-cycle schedule model.
module tb_window_broadcaster;

  localparam int DW   = 16;
  localparam int AW   = 16;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic          round;
  logic [7:0]    image_dim;
  logic [1:0]    padding;
  logic [7:0]    x_min, x_max, y_min, y_max;
  logic [AW-1:0] mem_addr;
  logic          mem_en;
  logic [DW-1:0] mem_data;
  logic [7:0]    bcast_x, bcast_y;
  logic [DW-1:0] bcast_pixel;
  logic          bcast_valid, bcast_busy, bcast_done, overrun;

  window_broadcaster #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .image_dim(image_dim), .padding(padding),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max), .round(round),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_data(mem_data),
    .bcast_x(bcast_x), .bcast_y(bcast_y), .bcast_pixel(bcast_pixel),
    .bcast_valid(bcast_valid), .bcast_busy(bcast_busy), .bcast_done(bcast_done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: data = addr+100 one cycle after a strobe, junk otherwise.
  always @(posedge clk) mem_data <= mem_en ? DW'(mem_addr + 16'd100) : DW'($urandom);

  // Expected per-cycle outputs, indexed by cycle number.
  bit        e_valid[MAXC];
  bit [7:0]  e_x[MAXC];
  bit [7:0]  e_y[MAXC];
  bit [15:0] e_pix[MAXC];
  bit        e_men[MAXC];
  bit [15:0] e_addr[MAXC];
  bit        e_busy[MAXC];
  bit        e_done[MAXC];

  int busy_last = -1;
  bit m_rq = 1'b0;
  bit m_ovr = 1'b0;

  int errors = 0;
  int checks = 0;
  int dut_done_cyc = -1;
  int dut_beats = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // A round started at T covers the window in raster order: issue at T+1+k, beat one cycle later.
  task automatic sched(input int T, input int xmn, input int xmx, input int ymn, input int ymx,
                       input int dim, input int pad);
    int k;
    int t;
    bit hit;
    if (xmn > xmx || ymn > ymx) begin
      if (T + 1 < MAXC) begin
        e_busy[T+1] = 1'b1;
        e_done[T+1] = 1'b1;
      end
      busy_last = T + 1;
    end else begin
      k = 0;
      for (int y = ymn; y <= ymx; y++) begin
        for (int x = xmn; x <= xmx; x++) begin
          t = T + 1 + k;
          hit = (x >= pad) && (x < dim + pad) && (y >= pad) && (y < dim + pad);
          if (t + 1 < MAXC) begin
            e_men[t]     = hit;
            e_addr[t]    = 16'((y - pad) * dim + (x - pad));
            e_valid[t+1] = 1'b1;
            e_x[t+1]     = 8'(x);
            e_y[t+1]     = 8'(y);
            e_pix[t+1]   = hit ? 16'((y - pad) * dim + (x - pad) + 100) : 16'd0;
          end
          k++;
        end
      end
      for (int c = T + 1; c <= T + 2 + k; c++) begin
        if (c < MAXC) e_busy[c] = 1'b1;
      end
      if (T + 2 + k < MAXC) e_done[T+2+k] = 1'b1;
      busy_last = T + 2 + k;
    end
  endtask

  // Compare DUT against the model each cycle, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    int c;
    bit st;
    c = cyc;
    if (c >= 1 && c < MAXC) begin
      check("valid", int'(bcast_valid), int'(e_valid[c]));
      check("done", int'(bcast_done), int'(e_done[c]));
      check("busy", int'(bcast_busy), int'(e_busy[c]));
      check("mem_en", int'(mem_en), int'(e_men[c]));
      check("overrun", int'(overrun), int'(m_ovr));
      if (e_valid[c]) begin
        check("bcast_x", int'(bcast_x), int'(e_x[c]));
        check("bcast_y", int'(bcast_y), int'(e_y[c]));
        check("pixel", int'(bcast_pixel), int'(e_pix[c]));
      end
      if (e_men[c]) check("mem_addr", int'(mem_addr), int'(e_addr[c]));
      if (bcast_done) dut_done_cyc = c;
      if (bcast_valid) dut_beats++;
      if (rst) begin
        for (int i = c + 1; i < c + 300 && i < MAXC; i++) begin
          e_valid[i] = 1'b0; e_men[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
        end
        busy_last = -1;
        m_ovr = 1'b0;
        m_rq = 1'b0;
      end else begin
        st = round && !m_rq;
        m_rq = round;
        if (st) begin
          if (c >= busy_last) sched(c, int'(x_min), int'(x_max), int'(y_min), int'(y_max),
                                    int'(image_dim), int'(padding));
          else m_ovr = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_win(input int dim, input int pad, input int xa, input int xb,
                         input int ya, input int yb);
    image_dim = 8'(dim); padding = 2'(pad);
    x_min = 8'(xa); x_max = 8'(xb); y_min = 8'(ya); y_max = 8'(yb);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    int T;
    int T2;
    int hold;
    int gap;
    rst = 1'b1; round = 1'b0;
    set_win(4, 1, 255, 0, 0, 0);
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();

    // Basic padded scan: 4x4 image, pad 1, window 0..2 x 0..2.
    set_win(4, 1, 0, 2, 0, 2);
    dut_beats = 0; round = 1'b1; T = cyc;
    step(); step(); round = 1'b0;
    repeat (12) step();
    check("pin_pix_1_1", int'(e_pix[T+6]), 100);
    check("pin_x_1_1", int'(e_x[T+6]), 1);
    check("pin_pix_2_2", int'(e_pix[T+10]), 105);
    check("pin_first_beat", int'(e_valid[T+2]), 1);
    check("pin_no_beat_T11", int'(e_valid[T+11]), 0);
    check("pin_men_corner", int'(e_men[T+1]), 0);
    check("basic_done_cycle", dut_done_cyc, T + 11);
    check("basic_beats", dut_beats, 9);

    // Empty window.
    set_win(4, 1, 255, 0, 0, 2);
    dut_beats = 0; round = 1'b1; T = cyc;
    step(); round = 1'b0;
    repeat (5) step();
    check("pin_empty_done", int'(e_done[T+1]), 1);
    check("empty_done_cycle", dut_done_cyc, T + 1);
    check("empty_beats", dut_beats, 0);

    // Early advance with bound changes mid-scan.
    set_win(4, 1, 1, 3, 1, 3);
    dut_beats = 0; round = 1'b1; T = cyc;
    repeat (4) step();
    round = 1'b0; set_win(9, 3, 7, 8, 6, 200);
    repeat (10) step();
    check("early_done_cycle", dut_done_cyc, T + 11);
    check("early_beats", dut_beats, 9);

    // Reset mid-scan.
    set_win(4, 1, 0, 2, 0, 2);
    dut_done_cyc = -1; round = 1'b1; T = cyc;
    repeat (5) step();
    rst = 1'b1; step(); rst = 1'b0; round = 1'b0;
    check("rst_valid", int'(bcast_valid), 0);
    check("rst_busy", int'(bcast_busy), 0);
    check("rst_pixel", int'(bcast_pixel), 0);
    repeat (10) step();
    check("rst_no_done", dut_done_cyc, -1);
    dut_beats = 0; round = 1'b1; T = cyc;
    step(); round = 1'b0;
    repeat (12) step();
    check("post_rst_done", dut_done_cyc, T + 11);
    check("post_rst_beats", dut_beats, 9);

    // Back-to-back: second start coincident with the FIN cycle.
    set_win(4, 1, 0, 2, 0, 2);
    dut_beats = 0; round = 1'b1; T = cyc;
    step(); round = 1'b0;
    while (cyc < T + 11) step();
    set_win(3, 0, 1, 2, 0, 1);
    round = 1'b1; T2 = cyc;
    step(); round = 1'b0;
    repeat (8) step();
    check("pin_b2b_first", int'(e_valid[T2+2]), 1);
    check("b2b_done", dut_done_cyc, T2 + 6);
    check("b2b_beats", dut_beats, 13);
    check("b2b_overrun", int'(overrun), 0);

    // Edge coordinates: y_max = 255 must end the scan, not wrap.
    set_win(255, 1, 250, 252, 253, 255);
    dut_beats = 0; round = 1'b1; T = cyc;
    step(); round = 1'b0;
    repeat (14) step();
    check("edge_done", dut_done_cyc, T + 11);
    check("edge_beats", dut_beats, 9);

    // Overrun: second rising edge mid-scan is dropped but flagged.
    set_win(4, 1, 0, 2, 0, 2);
    dut_beats = 0; round = 1'b1; T = cyc;
    repeat (4) step();
    round = 1'b0; step(); round = 1'b1; step(); round = 1'b0;
    repeat (14) step();
    check("ovr_done", dut_done_cyc, T + 11);
    check("ovr_beats", dut_beats, 9);
    check("ovr_flag", int'(overrun), 1);
    rst = 1'b1; step(); rst = 1'b0; step();

    // Randomized rounds with glitches, bound churn and occasional resets.
    for (int it = 0; it < 60; it++) begin
      int dim, pad, span, xa, ya;
      dim = $urandom_range(1, 12); pad = $urandom_range(0, 3); span = dim + 2 * pad;
      xa = $urandom_range(0, span); ya = $urandom_range(0, span);
      set_win(dim, pad, xa, xa + $urandom_range(0, 4) - ($urandom_range(0, 7) == 0 ? 6 : 0),
              ya, ya + $urandom_range(0, 4));
      round = 1'b1;
      hold = $urandom_range(1, 8);
      repeat (hold) begin
        step();
        if ($urandom_range(0, 5) == 0) x_max = 8'($urandom);
      end
      round = 1'b0;
      gap = $urandom_range(0, 30);
      repeat (gap) begin
        step();
        round = ($urandom_range(0, 12) == 0);
        rst = ($urandom_range(0, 150) == 0);
      end
      rst = 1'b0; round = 1'b0;
      if (it % 10 == 9) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
      step();
    end
    repeat (60) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
